// File: rtl/bus_access_arbiter_pkg.sv
// Shared cache-side types: who owns the memory port, what kind of
// transaction it carries, and the arbiter state encoding.
package bus_access_arbiter_pkg;

    typedef enum logic {
        Requester_Inst = 1'b0,
        Requester_Data = 1'b1
    } MemRequester;

    typedef enum logic {
        MemOp_Read  = 1'b0,
        MemOp_Write = 1'b1
    } MemOp;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } ArbState;

    // The side that did not win; used to hand priority to the loser.
    function automatic MemRequester other_side(MemRequester r);
        return (r == Requester_Inst) ? Requester_Data : Requester_Inst;
    endfunction

endpackage

// File: rtl/bus_access_arbiter_picker.sv
// Two-way round-robin pick. Purely combinational; the priority pointer
// lives in the parent so it only moves when a transaction completes.
module round_robin_picker2
    import bus_access_arbiter_pkg::*;
(
    input  logic ic_req_i,
    input  logic dc_req_i,
    input  logic ptr_i,      // preferred side when both request
    output logic winner_o,   // MemRequester encoding
    output logic any_req_o
);

    // Single requester wins outright; a tie goes to the pointer.
    always_comb begin
        any_req_o = ic_req_i | dc_req_i;
        winner_o  = ptr_i;
        if (ic_req_i && !dc_req_i) begin
            winner_o = Requester_Inst;
        end else if (dc_req_i && !ic_req_i) begin
            winner_o = Requester_Data;
        end
    end

endmodule

// File: rtl/bus_access_arbiter.sv
// Shares the single line-wide memory port between the fetch unit (ic_*)
// and the load/store unit (dc_*). One transaction outstanding at a time.
//
// Handshake: a requester raises read_req/write_req with addr/data and holds
// them stable until its one-cycle grant pulse, then drops req. The memory
// side sees mem_*_req held high from registers until a one-cycle mem_done;
// mem_read_value is sampled only with mem_done while in ISSUE.
module bus_access_arbiter
    import bus_access_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] ic_addr,
    input  logic                  ic_read_req,
    input  logic                  ic_write_req,
    input  logic [LINE_WIDTH-1:0] ic_write_value,
    output logic                  ic_read_grant,
    output logic                  ic_write_grant,
    output logic [LINE_WIDTH-1:0] ic_read_value,

    input  logic [ADDR_WIDTH-1:0] dc_addr,
    input  logic                  dc_read_req,
    input  logic                  dc_write_req,
    input  logic [LINE_WIDTH-1:0] dc_write_value,
    output logic                  dc_read_grant,
    output logic                  dc_write_grant,
    output logic [LINE_WIDTH-1:0] dc_read_value,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read_req,
    output logic                  mem_write_req,
    output logic [LINE_WIDTH-1:0] mem_write_value,
    input  logic                  mem_done,
    input  logic [LINE_WIDTH-1:0] mem_read_value,

    output logic [1:0]            arb_state_o   // ArbState, for observation
);

    ArbState               state_q;
    MemRequester           winner_q;
    MemRequester           ptr_q;
    MemOp                  op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wval_q;
    logic                  mem_rd_q;
    logic                  mem_wr_q;
    logic [LINE_WIDTH-1:0] ic_rv_q;
    logic [LINE_WIDTH-1:0] dc_rv_q;
    logic                  ic_rg_q;
    logic                  ic_wg_q;
    logic                  dc_rg_q;
    logic                  dc_wg_q;

    logic                  winner_w;
    logic                  any_req_w;
    logic                  pick_wr_w;

    round_robin_picker2 u_picker (
        .ic_req_i  (ic_read_req | ic_write_req),
        .dc_req_i  (dc_read_req | dc_write_req),
        .ptr_i     (ptr_q),
        .winner_o  (winner_w),
        .any_req_o (any_req_w)
    );

    // A write beats a same-side read; the read is re-arbitrated later.
    assign pick_wr_w = (winner_w == Requester_Data) ? dc_write_req : ic_write_req;

    // Arbitration FSM; every output it drives is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            winner_q <= Requester_Inst;
            ptr_q    <= Requester_Data;
            op_q     <= MemOp_Read;
            addr_q   <= '0;
            wval_q   <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            ic_rv_q  <= '0;
            dc_rv_q  <= '0;
            ic_rg_q  <= 1'b0;
            ic_wg_q  <= 1'b0;
            dc_rg_q  <= 1'b0;
            dc_wg_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req_w) begin
                        winner_q <= MemRequester'(winner_w);
                        op_q     <= pick_wr_w ? MemOp_Write : MemOp_Read;
                        mem_rd_q <= !pick_wr_w;
                        mem_wr_q <= pick_wr_w;
                        if (winner_w == Requester_Data) begin
                            addr_q <= dc_addr;
                            wval_q <= dc_write_value;
                        end else begin
                            addr_q <= ic_addr;
                            wval_q <= ic_write_value;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_done) begin
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        if (op_q == MemOp_Read) begin
                            if (winner_q == Requester_Data) begin
                                dc_rv_q <= mem_read_value;
                                dc_rg_q <= 1'b1;
                            end else begin
                                ic_rv_q <= mem_read_value;
                                ic_rg_q <= 1'b1;
                            end
                        end else begin
                            if (winner_q == Requester_Data) begin
                                dc_wg_q <= 1'b1;
                            end else begin
                                ic_wg_q <= 1'b1;
                            end
                        end
                        state_q <= RESPOND;
                    end
                end
                RESPOND: begin
                    // Grant cycle: no arbitration, so a still-held req is not
                    // served twice; priority moves to the side that lost.
                    ic_rg_q <= 1'b0;
                    ic_wg_q <= 1'b0;
                    dc_rg_q <= 1'b0;
                    dc_wg_q <= 1'b0;
                    ptr_q   <= other_side(winner_q);
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ic_read_grant   = ic_rg_q;
    assign ic_write_grant  = ic_wg_q;
    assign ic_read_value   = ic_rv_q;
    assign dc_read_grant   = dc_rg_q;
    assign dc_write_grant  = dc_wg_q;
    assign dc_read_value   = dc_rv_q;
    assign mem_addr        = addr_q;
    assign mem_read_req    = mem_rd_q;
    assign mem_write_req   = mem_wr_q;
    assign mem_write_value = wval_q;
    assign arb_state_o     = state_q;

endmodule

// File: tb/tb_bus_access_arbiter.sv
// Directed bench for bus_access_arbiter: hand-computed expectations for
// single read, simultaneous requests, fairness, same-side conflict,
// input changes while busy, stray mem_done and reset mid-transaction.
module tb_bus_access_arbiter;
  localparam int AW = 28;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ic_addr = '0, dc_addr = '0;
  logic          ic_read_req = 0, ic_write_req = 0, dc_read_req = 0, dc_write_req = 0;
  logic [LW-1:0] ic_write_value = '0, dc_write_value = '0;
  logic          ic_read_grant, ic_write_grant, dc_read_grant, dc_write_grant;
  logic [LW-1:0] ic_read_value, dc_read_value;
  logic [AW-1:0] mem_addr;
  logic          mem_read_req, mem_write_req;
  logic [LW-1:0] mem_write_value;
  logic          mem_done = 1'b0;
  logic [LW-1:0] mem_read_value = '0;
  logic [1:0]    arb_state;

  int checks = 0;
  int errors = 0;

  bus_access_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .ic_addr(ic_addr), .ic_read_req(ic_read_req), .ic_write_req(ic_write_req),
    .ic_write_value(ic_write_value), .ic_read_grant(ic_read_grant),
    .ic_write_grant(ic_write_grant), .ic_read_value(ic_read_value),
    .dc_addr(dc_addr), .dc_read_req(dc_read_req), .dc_write_req(dc_write_req),
    .dc_write_value(dc_write_value), .dc_read_grant(dc_read_grant),
    .dc_write_grant(dc_write_grant), .dc_read_value(dc_read_value),
    .mem_addr(mem_addr), .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_write_value(mem_write_value), .mem_done(mem_done),
    .mem_read_value(mem_read_value), .arb_state_o(arb_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // advance one cycle; inputs change and outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ic_read_req = 0; ic_write_req = 0; dc_read_req = 0; dc_write_req = 0;
    mem_done = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  // wait (bounded) for a memory request to appear
  task automatic wait_mem(input string tag);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_read_req || mem_write_req) begin
        seen = 1;
        break;
      end
      step();
    end
    check({tag, "_mem_req_seen"}, LW'(seen), LW'(1));
  endtask

  // pulse mem_done for one cycle; returns in the grant cycle
  task automatic mem_complete(input logic [LW-1:0] rdata);
    mem_done = 1'b1;
    mem_read_value = rdata;
    step();
    mem_done = 1'b0;
  endtask

  // grants as {ic_rd, ic_wr, dc_rd, dc_wr}
  function automatic logic [3:0] grants();
    return {ic_read_grant, ic_write_grant, dc_read_grant, dc_write_grant};
  endfunction

  logic [LW-1:0] v_beef, v_a5;
  logic [AW-1:0] fair_addr;

  initial begin
    v_beef = {4{32'hDEADBEEF}};
    v_a5   = {16{8'hA5}};

    // reset state
    do_reset();
    check("rst_state", LW'(arb_state), LW'(0));
    check("rst_grants", LW'(grants()), LW'(0));
    check("rst_mem_req", LW'({mem_read_req, mem_write_req}), LW'(0));
    check("rst_mem_addr", LW'(mem_addr), LW'(0));
    check("rst_ic_rv", ic_read_value, '0);
    check("rst_dc_rv", dc_read_value, '0);

    // single read: req at cycle 0, mem req at 1, done at 5, grant at 6
    ic_addr = 28'h0000123;
    ic_read_req = 1;
    step();
    check("t1_mem_rd_c1", LW'(mem_read_req), LW'(1));
    check("t1_mem_wr_c1", LW'(mem_write_req), LW'(0));
    check("t1_mem_addr", LW'(mem_addr), LW'(28'h0000123));
    for (int c = 2; c <= 5; c++) begin
      step();
      check("t1_mem_rd_held", LW'(mem_read_req), LW'(1));
    end
    mem_complete(v_beef);
    check("t1_grants_c6", LW'(grants()), LW'(4'b1000));
    check("t1_ic_rv", ic_read_value, v_beef);
    check("t1_mem_rd_off", LW'(mem_read_req), LW'(0));
    step();
    ic_read_req = 0;
    check("t1_grants_c7", LW'(grants()), LW'(0));
    step();
    step();
    check("t1_no_reserve", LW'({mem_read_req, mem_write_req}), LW'(0));

    // simultaneous after reset: data write first, ic read at grant+2
    do_reset();
    ic_addr = 28'h0000200;
    ic_read_req = 1;
    dc_addr = 28'h40;
    dc_write_value = v_a5;
    dc_write_req = 1;
    step();
    check("t2_mem_wr", LW'(mem_write_req), LW'(1));
    check("t2_mem_rd", LW'(mem_read_req), LW'(0));
    check("t2_mem_addr", LW'(mem_addr), LW'(28'h40));
    check("t2_mem_wval", mem_write_value, v_a5);
    mem_complete(v_beef);
    check("t2_grants_dw", LW'(grants()), LW'(4'b0001));
    check("t2_dc_rv_kept", dc_read_value, '0);
    dc_write_req = 0;
    step();
    check("t2_gap", LW'({mem_read_req, mem_write_req}), LW'(0));
    step();
    check("t2_ic_rd_g2", LW'(mem_read_req), LW'(1));
    check("t2_ic_addr", LW'(mem_addr), LW'(28'h0000200));
    mem_complete({4{32'h11112222}});
    check("t2_grants_ir", LW'(grants()), LW'(4'b1000));
    check("t2_ic_rv", ic_read_value, {4{32'h11112222}});
    ic_read_req = 0;
    step();

    // fairness: both hold reads; expect D, I, D, I, D, I
    do_reset();
    ic_addr = 28'h0000AAA;
    dc_addr = 28'h0000DDD;
    ic_read_req = 1;
    dc_read_req = 1;
    for (int t = 0; t < 6; t++) begin
      step();
      wait_mem("t3");
      fair_addr = (t % 2 == 0) ? 28'h0000DDD : 28'h0000AAA;
      check("t3_addr", LW'(mem_addr), LW'(fair_addr));
      mem_complete(LW'(t + 100));
      check("t3_grants", LW'(grants()), (t % 2 == 0) ? LW'(4'b0010) : LW'(4'b1000));
      if (t % 2 == 0) check("t3_dc_rv", dc_read_value, LW'(t + 100));
      else            check("t3_ic_rv", ic_read_value, LW'(t + 100));
    end
    ic_read_req = 0;
    dc_read_req = 0;
    step();

    // same-side conflict: write first, then read
    do_reset();
    dc_addr = 28'h77;
    dc_write_value = {4{32'hCAFEF00D}};
    dc_read_req = 1;
    dc_write_req = 1;
    step();
    check("t4_first_wr", LW'({mem_read_req, mem_write_req}), LW'(2'b01));
    mem_complete('0);
    check("t4_grant_wr", LW'(grants()), LW'(4'b0001));
    dc_write_req = 0;
    step();
    wait_mem("t4");
    check("t4_second_rd", LW'({mem_read_req, mem_write_req}), LW'(2'b10));
    mem_complete({4{32'h5A5A5A5A}});
    check("t4_grant_rd", LW'(grants()), LW'(4'b0010));
    check("t4_dc_rv", dc_read_value, {4{32'h5A5A5A5A}});
    dc_read_req = 0;
    step();

    // input change while busy, then stray mem_done in IDLE
    ic_addr = 28'h0000300;
    ic_read_req = 1;
    step();
    ic_addr = 28'h0FFFFFF;
    step();
    check("t5_addr_latched", LW'(mem_addr), LW'(28'h0000300));
    mem_complete({4{32'h01020304}});
    check("t5_grant", LW'(grants()), LW'(4'b1000));
    ic_read_req = 0;
    step();
    step();
    mem_done = 1;
    mem_read_value = {4{32'hBADBAD00}};
    step();
    mem_done = 0;
    check("t5_stray_grants", LW'(grants()), LW'(0));
    check("t5_stray_state", LW'(arb_state), LW'(0));
    check("t5_stray_ic_rv", ic_read_value, {4{32'h01020304}});
    step();
    check("t5_stray_grants2", LW'(grants()), LW'(0));

    // reset mid-transaction; afterwards the data side wins a tie
    ic_addr = 28'h0000400;
    ic_read_req = 1;
    step();
    check("t6_issue", LW'(arb_state), LW'(1));
    rst = 1;
    step();
    rst = 0;
    check("t6_mem_rd_off", LW'(mem_read_req), LW'(0));
    check("t6_grants", LW'(grants()), LW'(0));
    check("t6_state", LW'(arb_state), LW'(0));
    dc_addr = 28'h0000500;
    dc_read_req = 1;
    step();
    check("t6_dc_wins", LW'(mem_addr), LW'(28'h0000500));
    mem_complete({4{32'h77778888}});
    check("t6_dc_grant", LW'(grants()), LW'(4'b0010));
    ic_read_req = 0;
    dc_read_req = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
